// File: rtl/nios2e_cpu_debug_pkg.sv
// Shared definitions for the on-chip debug memory block: RAM geometry,
// the bit positions of the fields carried in the 38-bit JTAG data word,
// and the access sequencer state encoding.
package nios2e_cpu_debug_pkg;

  localparam int OCIMEM_DEPTH = 256;
  localparam int OCIMEM_AW    = 8;

  localparam int JDO_W       = 38;
  localparam int JDO_ADDR_HI = 33;
  localparam int JDO_ADDR_LO = 26;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  localparam int JDO_ERR_CLR = 25;
  localparam int JDO_RD_EN   = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_JRD   = 3'd1,
    ST_JCAP  = 3'd2,
    ST_JWR   = 3'd3,
    ST_CPURD = 3'd4
  } ocimem_state_t;

  function automatic logic [OCIMEM_AW-1:0] jdo_addr(input logic [JDO_W-1:0] j);
    return j[JDO_ADDR_HI:JDO_ADDR_LO];
  endfunction

  function automatic logic [31:0] jdo_data(input logic [JDO_W-1:0] j);
    return j[JDO_DATA_HI:JDO_DATA_LO];
  endfunction

endpackage

// File: rtl/nios2e_cpu_ocimem_ram.sv
// Single-port synchronous debug RAM, 32-bit words with per-byte write enables.
// Read data is registered: valid the cycle after re, held until the next read.
// Contents are never reset.
module nios2e_cpu_ocimem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  input  logic          we,
  input  logic          re,
  output logic [31:0]   q
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write and registered read share the single address port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) q <= mem[addr];
  end

endmodule

// File: rtl/nios2e_cpu_ocimem_access.sv
// Arbitrates the debug RAM between the JTAG monitor and the CPU Avalon slave.
// JTAG read: ready 2 cycles after the command; CPU write 0 wait, CPU read 1 wait.
// JTAG wins ties; CPU requests see waitrequest until served; late JTAG commands flag an error.
module nios2e_cpu_ocimem_access
  import nios2e_cpu_debug_pkg::*;
#(
  parameter int DEPTH = OCIMEM_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [JDO_W-1:0] jdo,
  input  logic             take_action_ocimem_a,
  input  logic             take_action_ocimem_b,
  input  logic             take_no_action_ocimem_a,
  input  logic [7:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic [3:0]       avs_byteenable,
  output logic [31:0]      avs_readdata,
  output logic             avs_waitrequest,
  output logic [31:0]      MonDReg,
  output logic             monitor_ready,
  output logic             monitor_error
);

  ocimem_state_t        state;
  logic [OCIMEM_AW-1:0] MonAReg;
  logic [31:0]          rd_hold;

  logic                 jtag_pulse;
  logic                 cpu_wr_take;
  logic                 cpu_rd_done;
  logic [OCIMEM_AW-1:0] ram_addr;
  logic [31:0]          ram_wdata;
  logic [3:0]           ram_be;
  logic                 ram_we;
  logic                 ram_re;
  logic [31:0]          ram_q;

  // jdo bits outside every field are intentionally ignored.
  logic                 unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign jtag_pulse  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // A CPU write is only taken in an idle cycle that no JTAG command claims.
  assign cpu_wr_take = (state == ST_IDLE) & ~jtag_pulse & avs_write & ~avs_read & ~reset;
  assign cpu_rd_done = (state == ST_CPURD) & avs_read;

  assign avs_waitrequest = (avs_read | avs_write) & ~(cpu_wr_take | cpu_rd_done);
  // The RAM output register carries the answer during CPURD; afterwards a copy
  // is held so later JTAG reads of the RAM do not disturb the CPU's data.
  assign avs_readdata    = (state == ST_CPURD) ? ram_q : rd_hold;

  // Steer the single RAM port from whichever side owns the current cycle.
  always_comb begin
    ram_addr  = MonAReg;
    ram_wdata = jdo_data(jdo);
    ram_be    = 4'hF;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cpu_wr_take) begin
          ram_addr  = avs_address;
          ram_wdata = avs_writedata;
          ram_be    = avs_byteenable;
          ram_we    = 1'b1;
        end else if (~jtag_pulse & avs_read) begin
          ram_addr = avs_address;
          ram_re   = 1'b1;
        end
      end
      ST_JRD:  ram_re = 1'b1;
      ST_JWR:  ram_we = ~reset;
      default: ;
    endcase
  end

  // Access sequencer with registered monitor outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      rd_hold       <= '0;
    end else begin
      if (jtag_pulse && state != ST_IDLE) monitor_error <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            MonAReg <= jdo_addr(jdo);
            if (jdo[JDO_ERR_CLR]) monitor_error <= 1'b0;
            if (jdo[JDO_RD_EN]) begin
              monitor_ready <= 1'b0;
              state         <= ST_JRD;
            end
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            state         <= ST_JRD;
          end else if (take_action_ocimem_b) begin
            state <= ST_JWR;
          end else if (avs_read) begin
            state <= ST_CPURD;
          end
        end
        ST_JRD: state <= ST_JCAP;
        ST_JCAP: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          MonAReg       <= MonAReg + 1'b1;
          state         <= ST_IDLE;
        end
        ST_JWR: begin
          MonDReg <= jdo_data(jdo);
          MonAReg <= MonAReg + 1'b1;
          state   <= ST_IDLE;
        end
        ST_CPURD: begin
          rd_hold <= ram_q;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  nios2e_cpu_ocimem_ram #(
    .DEPTH(DEPTH),
    .AW   (OCIMEM_AW)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .be   (ram_be),
    .we   (ram_we),
    .re   (ram_re),
    .q    (ram_q)
  );

endmodule

// File: tb/tb_nios2e_cpu_ocimem_access.sv
// Randomized bench for the debug RAM arbiter against a transaction-level model
// (word array, address pointer, monitor status), plus directed corner cases.
module tb_nios2e_cpu_ocimem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [31:0] mem_m [256];
  logic [7:0]  a_m;
  logic [31:0] d_m;
  logic        rdy_m, err_m;
  logic [31:0] last_rd;

  nios2e_cpu_ocimem_access dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avs_address            (avs_address),
    .avs_read               (avs_read),
    .avs_write              (avs_write),
    .avs_writedata          (avs_writedata),
    .avs_byteenable         (avs_byteenable),
    .avs_readdata           (avs_readdata),
    .avs_waitrequest        (avs_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] rnd_jdo();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_mondreg"}, MonDReg, d_m);
    chk({tag, "_ready"}, monitor_ready, rdy_m);
    chk({tag, "_error"}, monitor_error, err_m);
    chk({tag, "_monareg"}, dut.MonAReg, a_m);
    chk({tag, "_rddata_hold"}, avs_readdata, last_rd);
  endtask

  task automatic jtag_write(input logic [31:0] data);
    logic [37:0] j;
    j = rnd_jdo();
    j[34:3] = data;
    @(negedge clk);
    jdo = j;
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    @(negedge clk);
    mem_m[a_m] = data;
    d_m = data;
    a_m = a_m + 8'd1;
    check_state("jwr");
  endtask

  task automatic jtag_set_addr(input logic [7:0] addr, input logic errclr);
    logic [37:0] j;
    j = rnd_jdo();
    j[33:26] = addr;
    j[25] = errclr;
    j[17] = 1'b0;
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    a_m = addr;
    if (errclr) err_m = 1'b0;
    check_state("jset");
  endtask

  task automatic jtag_read(input logic use_a, input logic [7:0] addr, input logic errclr);
    logic [37:0] j;
    j = rnd_jdo();
    j[33:26] = addr;
    j[25] = errclr;
    j[17] = 1'b1;
    @(negedge clk);
    jdo = j;
    if (use_a) take_action_ocimem_a = 1'b1;
    else take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    @(negedge clk);
    chk("jrd_ready_early", monitor_ready, 1'b0);
    @(negedge clk);
    if (use_a) begin
      a_m = addr;
      if (errclr) err_m = 1'b0;
    end
    d_m = mem_m[a_m];
    a_m = a_m + 8'd1;
    rdy_m = 1'b1;
    check_state("jrd");
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    avs_address = addr;
    avs_writedata = data;
    avs_byteenable = be;
    avs_write = 1'b1;
    #1 chk("cwr_wait", avs_waitrequest, 1'b0);
    @(negedge clk);
    avs_write = 1'b0;
    for (int i = 0; i < 4; i++)
      if (be[i]) mem_m[addr][8*i +: 8] = data[8*i +: 8];
  endtask

  task automatic cpu_read(input logic [7:0] addr);
    int waits;
    @(negedge clk);
    avs_address = addr;
    avs_read = 1'b1;
    #1 chk("crd_wait_first", avs_waitrequest, 1'b1);
    waits = 0;
    while (waits < 8) begin
      @(negedge clk);
      waits++;
      if (!avs_waitrequest) break;
    end
    chk("crd_wait_states", waits, 1);
    last_rd = mem_m[addr];
    chk("crd_data", avs_readdata, last_rd);
    avs_read = 1'b0;
  endtask

  // CPU read and JTAG write arrive together: JTAG write goes first.
  task automatic collide();
    logic [37:0] j;
    logic [31:0] data;
    logic [7:0]  addr;
    int waits;
    data = $urandom();
    addr = a_m;
    j = rnd_jdo();
    j[34:3] = data;
    @(negedge clk);
    jdo = j;
    take_action_ocimem_b = 1'b1;
    avs_address = addr;
    avs_read = 1'b1;
    #1 chk("coll_wait_first", avs_waitrequest, 1'b1);
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    waits = 1;
    while (avs_waitrequest && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    chk("coll_waits", waits, 3);
    mem_m[a_m] = data;
    d_m = data;
    a_m = a_m + 8'd1;
    last_rd = mem_m[addr];
    chk("coll_rddata", avs_readdata, last_rd);
    avs_read = 1'b0;
    check_state("coll");
  endtask

  // A JTAG command issued while a read is in flight is dropped and flagged.
  task automatic err_test();
    logic [7:0] rd_addr;
    rd_addr = a_m;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    jdo = rnd_jdo();
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    @(negedge clk);
    d_m = mem_m[a_m];
    a_m = a_m + 8'd1;
    rdy_m = 1'b1;
    err_m = 1'b1;
    check_state("err_set");
    cpu_read(rd_addr);
    jtag_set_addr(a_m, 1'b1);
  endtask

  task automatic reset_in_jrd();
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    reset = 1'b1;
    a_m = 8'd0; d_m = '0; rdy_m = 1'b0; err_m = 1'b0; last_rd = '0;
    #1 check_state("rst_async");
    chk("rst_wait", avs_waitrequest, 1'b0);
    @(negedge clk);
    check_state("rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    a_m = '0; d_m = '0; rdy_m = 1'b0; err_m = 1'b0; last_rd = '0;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_wait", avs_waitrequest, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) cpu_write(i[7:0], $urandom(), 4'hF);

    // Byte-enabled CPU write over all-ones, then read back.
    cpu_write(8'h20, 32'hFFFF_FFFF, 4'hF);
    cpu_write(8'h20, 32'h1234_5678, 4'b0011);
    cpu_read(8'h20);

    // JTAG write at 0x10 then JTAG read back from 0x10.
    jtag_set_addr(8'h10, 1'b0);
    jtag_write(32'hDEAD_BEEF);
    jtag_read(1'b1, 8'h10, 1'b0);

    // Address pointer wraps from 0xFF.
    jtag_set_addr(8'hFF, 1'b0);
    jtag_read(1'b0, 8'h00, 1'b0);

    err_test();
    collide();
    reset_in_jrd();
    cpu_read(8'h20);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: jtag_write($urandom());
        1: jtag_read(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        2: jtag_read(1'b0, 8'h00, 1'b0);
        3: cpu_write(8'($urandom_range(0, 255)), $urandom(), 4'($urandom_range(0, 15)));
        4: cpu_read(8'($urandom_range(0, 255)));
        5: jtag_set_addr(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        6: err_test();
        default: collide();
      endcase
      @(negedge clk);
      check_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
